apb_uart: RTL and testbench

APB3 slave UART on the peripheral bus, at slave index 0, address window 0x4000_0000–0x4000_FFFF. It sits downstream of the AHB-to-APB bridge and decodes only `paddr[3:2]`. Transmit data goes through an 8-entry TX FIFO; receive data goes into a single holding register. It provides 8N1 serial framing, a programmable bit divisor and one level interrupt.

---
 rtl/apb_uart.sv | 373 +++++++++++++++++++++++++++++++++++++
 tb/tb_apb_uart.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_uart.sv
// apb_uart: APB3 slave UART with an 8-entry TX FIFO, single RX holding
// register, programmable bit divisor and one level interrupt.
// Optional feature macro: UART_PARITY_EN (even parity after D7 on TX and RX).
module apb_uart #(
    parameter int PADDR_WIDTH   = 16,
    parameter int DATA_WIDTH    = 32,
    parameter int TX_FIFO_DEPTH = 8,
    parameter int BAUD_DIV_RST  = 434
) (
    input  logic                    pclk,
    input  logic                    presetn,
    input  logic [PADDR_WIDTH-1:0]  paddr,
    input  logic                    psel,
    input  logic                    penable,
    input  logic                    pwrite,
    input  logic [DATA_WIDTH-1:0]   pwdata,
    input  logic [DATA_WIDTH/8-1:0] pstrb,
    output logic                    pready,
    output logic [DATA_WIDTH-1:0]   prdata,
    output logic                    uart_tx,
    input  logic                    uart_rx,
    output logic                    irq
);

    localparam int AW = $clog2(TX_FIFO_DEPTH);
    localparam logic [AW:0] FIFO_FULL = (AW+1)'(TX_FIFO_DEPTH);

    typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP} tx_state_t;
    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP} rx_state_t;

    // Bus decode
    logic       acc, wr_en, rd_en;
    logic [1:0] reg_sel;
    logic       push_req, push_ok, rd_data, status_wr, ctrl_wr, baud_wr;

    // Registers
    logic [15:0] baud, div_eff, half_div;
    logic        tx_en, rx_en, irq_rx_en, irq_txe_en;
    logic [7:0]  rx_data;
    logic        rx_valid, rx_ovr, frame_err, par_err, tx_ovf;
    logic [7:0]  status;

    // TX FIFO
    logic [7:0]  fifo_mem [TX_FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0] fifo_count;
    logic        fifo_full, fifo_empty;

    // TX engine
    tx_state_t   tx_state, tx_state_n;
    logic [15:0] tx_cnt;
    logic [2:0]  tx_bit;
    logic [7:0]  tx_shift;
    logic        tx_par, tx_tick, tx_pop, tx_line, tx_busy;

    // RX engine
    rx_state_t   rx_state, rx_state_n;
    logic        rx_s1, rx_s2, rx_prev;
    logic [15:0] rx_cnt;
    logic [2:0]  rx_bit;
    logic [7:0]  rx_shift;
    logic        rx_tick, rx_done, rx_stop_bad, rx_par_bad;

    logic unused_bits;

    assign acc       = psel & penable;
    assign wr_en     = acc & pwrite;
    assign rd_en     = acc & ~pwrite;
    assign reg_sel   = paddr[3:2];
    assign push_req  = wr_en && (reg_sel == 2'd0) && pstrb[0];
    assign push_ok   = push_req && !fifo_full;
    assign rd_data   = rd_en && (reg_sel == 2'd0);
    assign status_wr = wr_en && (reg_sel == 2'd1);
    assign baud_wr   = wr_en && (reg_sel == 2'd2);
    assign ctrl_wr   = wr_en && (reg_sel == 2'd3);
    assign pready    = 1'b1;

    assign fifo_full  = (fifo_count == FIFO_FULL);
    assign fifo_empty = (fifo_count == '0);

    assign div_eff  = (baud < 16'd4) ? 16'd4 : baud;
    assign half_div = {1'b0, div_eff[15:1]};
    assign tx_tick  = (tx_cnt == 16'd0);
    assign rx_tick  = (rx_cnt == 16'd0);
    assign tx_busy  = (tx_state != TX_IDLE);

    assign status = {tx_ovf, par_err, frame_err, tx_busy, rx_ovr, rx_valid, fifo_empty, fifo_full};

    assign unused_bits = &{1'b0, paddr[PADDR_WIDTH-1:4], paddr[1:0],
                           pwdata[DATA_WIDTH-1:16], pstrb[DATA_WIDTH/8-1:2], rx_par_bad};

    // FIFO storage; contents need no reset because occupancy guards reads
    always_ff @(posedge pclk) begin
        if (push_ok)
            fifo_mem[wr_ptr] <= pwdata[7:0];
    end

    // FIFO pointers and occupancy; simultaneous push and pop leave count unchanged
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push_ok)
                wr_ptr <= wr_ptr + 1'b1;
            if (tx_pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, tx_pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // Configuration registers: byte-strobed divisor and control bits
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            baud       <= 16'(BAUD_DIV_RST);
            tx_en      <= 1'b0;
            rx_en      <= 1'b0;
            irq_rx_en  <= 1'b0;
            irq_txe_en <= 1'b0;
        end else begin
            if (baud_wr && pstrb[0])
                baud[7:0] <= pwdata[7:0];
            if (baud_wr && pstrb[1])
                baud[15:8] <= pwdata[15:8];
            if (ctrl_wr) begin
                tx_en      <= pwdata[0];
                rx_en      <= pwdata[1];
                irq_rx_en  <= pwdata[2];
                irq_txe_en <= pwdata[3];
            end
        end
    end

    // TX state register
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn)
            tx_state <= TX_IDLE;
        else
            tx_state <= tx_state_n;
    end

    // TX next state, FIFO pop and line level for the current bit
    always_comb begin
        tx_state_n = tx_state;
        tx_pop     = 1'b0;
        tx_line    = 1'b1;
        case (tx_state)
            TX_IDLE: begin
                if (tx_en && !fifo_empty) begin
                    tx_state_n = TX_START;
                    tx_pop     = 1'b1;
                end
            end
            TX_START: begin
                tx_line = 1'b0;
                if (tx_tick)
                    tx_state_n = TX_DATA;
            end
            TX_DATA: begin
                tx_line = tx_shift[0];
                if (tx_tick && (tx_bit == 3'd7)) begin
`ifdef UART_PARITY_EN
                    tx_state_n = TX_PARITY;
`else
                    tx_state_n = TX_STOP;
`endif
                end
            end
            TX_PARITY: begin
                tx_line = tx_par;
                if (tx_tick)
                    tx_state_n = TX_STOP;
            end
            TX_STOP: begin
                tx_line = 1'b1;
                if (tx_tick) begin
                    if (tx_en && !fifo_empty) begin
                        tx_state_n = TX_START;
                        tx_pop     = 1'b1;
                    end else begin
                        tx_state_n = TX_IDLE;
                    end
                end
            end
            default: tx_state_n = TX_IDLE;
        endcase
    end

    // TX datapath: divisor is re-read at every bit boundary so BAUD writes apply on the next bit
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            tx_cnt   <= '0;
            tx_bit   <= '0;
            tx_shift <= '0;
            tx_par   <= 1'b0;
            uart_tx  <= 1'b1;
        end else begin
            uart_tx <= tx_line;
            if (tx_pop) begin
                tx_shift <= fifo_mem[rd_ptr];
                tx_par   <= ^fifo_mem[rd_ptr];
                tx_cnt   <= div_eff - 16'd1;
                tx_bit   <= '0;
            end else if (tx_state != TX_IDLE) begin
                if (tx_tick) begin
                    tx_cnt <= div_eff - 16'd1;
                    if (tx_state == TX_DATA) begin
                        tx_shift <= {1'b0, tx_shift[7:1]};
                        tx_bit   <= tx_bit + 3'd1;
                    end
                end else begin
                    tx_cnt <= tx_cnt - 16'd1;
                end
            end
        end
    end

    // RX two-flop synchronizer plus previous-value flop for falling-edge detection
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            rx_s1   <= 1'b1;
            rx_s2   <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_s1   <= uart_rx;
            rx_s2   <= rx_s1;
            rx_prev <= rx_s2;
        end
    end

    // RX state register
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn)
            rx_state <= RX_IDLE;
        else
            rx_state <= rx_state_n;
    end

    // RX next state and completion/error pulses; disabling RX aborts any frame
    always_comb begin
        rx_state_n  = rx_state;
        rx_done     = 1'b0;
        rx_stop_bad = 1'b0;
        rx_par_bad  = 1'b0;
        if (!rx_en) begin
            rx_state_n = RX_IDLE;
        end else begin
            case (rx_state)
                RX_IDLE: begin
                    if (rx_prev && !rx_s2)
                        rx_state_n = RX_START;
                end
                RX_START: begin
                    if (rx_tick)
                        rx_state_n = rx_s2 ? RX_IDLE : RX_DATA;
                end
                RX_DATA: begin
                    if (rx_tick && (rx_bit == 3'd7)) begin
`ifdef UART_PARITY_EN
                        rx_state_n = RX_PARITY;
`else
                        rx_state_n = RX_STOP;
`endif
                    end
                end
                RX_PARITY: begin
                    if (rx_tick) begin
                        rx_par_bad = rx_s2 ^ (^rx_shift);
                        rx_state_n = RX_STOP;
                    end
                end
                RX_STOP: begin
                    if (rx_tick) begin
                        rx_done     = 1'b1;
                        rx_stop_bad = ~rx_s2;
                        rx_state_n  = RX_IDLE;
                    end
                end
                default: rx_state_n = RX_IDLE;
            endcase
        end
    end

    // RX datapath: half-bit delay armed while idle, full-bit spacing afterwards
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            rx_cnt   <= '0;
            rx_bit   <= '0;
            rx_shift <= '0;
        end else if (rx_state == RX_IDLE) begin
            rx_cnt <= half_div - 16'd1;
            rx_bit <= '0;
        end else if (rx_tick) begin
            rx_cnt <= div_eff - 16'd1;
            if (rx_state == RX_DATA) begin
                rx_shift <= {rx_s2, rx_shift[7:1]};
                rx_bit   <= rx_bit + 3'd1;
            end
        end else begin
            rx_cnt <= rx_cnt - 16'd1;
        end
    end

    // Status flags: sticky bits clear on write-1, and a new event on the same edge wins
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            rx_ovr    <= 1'b0;
            frame_err <= 1'b0;
            par_err   <= 1'b0;
            tx_ovf    <= 1'b0;
        end else begin
            if (rx_done && (!rx_valid || rd_data)) begin
                rx_data  <= rx_shift;
                rx_valid <= 1'b1;
            end else if (rd_data) begin
                rx_valid <= 1'b0;
            end

            if (status_wr && pwdata[3])
                rx_ovr <= 1'b0;
            if (rx_done && rx_valid && !rd_data)
                rx_ovr <= 1'b1;

            if (status_wr && pwdata[5])
                frame_err <= 1'b0;
            if (rx_done && rx_stop_bad)
                frame_err <= 1'b1;

`ifdef UART_PARITY_EN
            if (status_wr && pwdata[6])
                par_err <= 1'b0;
            if (rx_par_bad)
                par_err <= 1'b1;
`else
            par_err <= 1'b0;
`endif

            if (status_wr && pwdata[7])
                tx_ovf <= 1'b0;
            if (push_req && fifo_full)
                tx_ovf <= 1'b1;
        end
    end

    // Registered level interrupt
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn)
            irq <= 1'b0;
        else
            irq <= (irq_rx_en & rx_valid) | (irq_txe_en & fifo_empty & ~tx_busy);
    end

    // Read mux, driven only while the slave is selected for a read
    always_comb begin
        prdata = '0;
        if (psel && !pwrite) begin
            case (reg_sel)
                2'd0: prdata = {{(DATA_WIDTH-8){1'b0}}, rx_data};
                2'd1: prdata = {{(DATA_WIDTH-8){1'b0}}, status};
                2'd2: prdata = {{(DATA_WIDTH-16){1'b0}}, baud};
                default: prdata = {{(DATA_WIDTH-4){1'b0}}, irq_txe_en, irq_rx_en, rx_en, tx_en};
            endcase
        end
    end

endmodule

// File: tb/tb_apb_uart.sv
// Directed self-checking bench for apb_uart (honours UART_PARITY_EN when defined).
module tb_apb_uart;

    localparam int RX_DIV = 8;

    logic        pclk = 1'b0;
    logic        presetn;
    logic [15:0] paddr;
    logic        psel, penable, pwrite;
    logic [31:0] pwdata;
    logic [3:0]  pstrb;
    logic        pready;
    logic [31:0] prdata;
    logic        uart_tx;
    logic        uart_rx;
    logic        irq;

    int tests_run    = 0;
    int tests_failed = 0;

    apb_uart dut (
        .pclk    (pclk),
        .presetn (presetn),
        .paddr   (paddr),
        .psel    (psel),
        .penable (penable),
        .pwrite  (pwrite),
        .pwdata  (pwdata),
        .pstrb   (pstrb),
        .pready  (pready),
        .prdata  (prdata),
        .uart_tx (uart_tx),
        .uart_rx (uart_rx),
        .irq     (irq)
    );

    // 100 MHz clock
    always #5 pclk = ~pclk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic apb_write(input logic [15:0] addr, input logic [31:0] data, input logic [3:0] strb);
        psel    = 1'b1;
        penable = 1'b0;
        pwrite  = 1'b1;
        paddr   = addr;
        pwdata  = data;
        pstrb   = strb;
        @(posedge pclk); #1;
        penable = 1'b1;
        @(posedge pclk); #1;
        psel    = 1'b0;
        penable = 1'b0;
        pwrite  = 1'b0;
    endtask

    task automatic apb_read(input logic [15:0] addr, output logic [31:0] data);
        psel    = 1'b1;
        penable = 1'b0;
        pwrite  = 1'b0;
        paddr   = addr;
        @(posedge pclk); #1;
        penable = 1'b1;
        #1;
        data = prdata;
        @(posedge pclk); #1;
        psel    = 1'b0;
        penable = 1'b0;
    endtask

    task automatic check_reg(input string tag, input logic [15:0] addr, input logic [31:0] exp);
        logic [31:0] val;
        apb_read(addr, val);
        checkOutput(tag, val, exp);
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge pclk);
        #1;
    endtask

    task automatic drive_bit(input logic b);
        uart_rx = b;
        wait_cycles(RX_DIV);
    endtask

    // Drive one serial frame on uart_rx at RX_DIV cycles per bit
    task automatic applyStimulus(input logic [7:0] data, input logic stop, input logic par_flip);
        logic pbit;
        pbit = (^data) ^ par_flip;
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++)
            drive_bit(data[i]);
`ifdef UART_PARITY_EN
        drive_bit(pbit);
`endif
        drive_bit(stop);
        uart_rx = 1'b1;
    endtask

    // Write one byte with BAUD=4 and TX enabled, then check start latency and every bit
    task automatic check_tx_frame(input logic [7:0] data, input string tag);
        logic [10:0] bits;
        int n;
`ifdef UART_PARITY_EN
        bits = {1'b1, ^data, data, 1'b0};
        n    = 11;
`else
        bits = {1'b0, 1'b1, data, 1'b0};
        n    = 10;
`endif
        apb_write(16'h0, {24'b0, data}, 4'hF);
        checkOutput({tag, "_line_idle"}, 32'(uart_tx), 32'h1);
        @(posedge pclk); #1;
        checkOutput({tag, "_latency"}, 32'(uart_tx), 32'h1);
        @(posedge pclk); #1;
        checkOutput({tag, "_start_edge"}, 32'(uart_tx), 32'h0);
        @(posedge pclk); #1;
        for (int k = 0; k < n; k++) begin
            checkOutput($sformatf("%s_bit%0d", tag, k), 32'(uart_tx), 32'(bits[k]));
            wait_cycles(4);
        end
    endtask

    initial begin
        logic [31:0] val;
        presetn = 1'b0;
        psel    = 1'b0;
        penable = 1'b0;
        pwrite  = 1'b0;
        paddr   = '0;
        pwdata  = '0;
        pstrb   = '0;
        uart_rx = 1'b1;

        #12;
        checkOutput("rst_uart_tx", 32'(uart_tx), 32'h1);
        checkOutput("rst_irq", 32'(irq), 32'h0);
        #10 presetn = 1'b1;
        @(posedge pclk); #1;
        checkOutput("rst_prdata", prdata, 32'h0);
        checkOutput("pready", 32'(pready), 32'h1);
        check_reg("rst_status", 16'h4, 32'h02);
        check_reg("rst_baud", 16'h8, 32'd434);
        check_reg("rst_ctrl", 16'hC, 32'h0);

        // Upper-byte-only BAUD write keeps the low byte (0x01B2 -> 0x12B2)
        apb_write(16'h8, 32'h0000_1234, 4'b0010);
        check_reg("baud_strobe", 16'h8, 32'h12B2);

        // Transmit 0xA5 at 4 cycles per bit
        apb_write(16'h8, 32'd4, 4'hF);
        apb_write(16'hC, 32'h1, 4'hF);
        check_tx_frame(8'hA5, "tx_a5");
        check_reg("tx_done_status", 16'h4, 32'h02);

        // TX_BUSY while in the start bit, FIFO already popped
        apb_write(16'h0, 32'h3C, 4'hF);
        check_reg("tx_busy_status", 16'h4, 32'h12);
        wait_cycles(50);
        check_reg("tx_idle_status", 16'h4, 32'h02);

        // TX-empty interrupt
        apb_write(16'hC, 32'h9, 4'hF);
        wait_cycles(2);
        checkOutput("irq_txe_on", 32'(irq), 32'h1);
        apb_write(16'hC, 32'h0, 4'hF);
        wait_cycles(2);
        checkOutput("irq_txe_off", 32'(irq), 32'h0);

        // Fill FIFO with TX disabled, then overflow once
        for (int i = 1; i <= 9; i++) begin
            apb_write(16'h0, 32'(i), 4'hF);
            check_reg($sformatf("fifo_fill%0d", i), 16'h4,
                      (i < 8) ? 32'h00 : ((i == 8) ? 32'h01 : 32'h81));
        end
        apb_write(16'h4, 32'h80, 4'hF);
        check_reg("tx_ovf_clear", 16'h4, 32'h01);
        apb_write(16'hC, 32'h1, 4'hF);
        wait_cycles(400);
        check_reg("fifo_drained", 16'h4, 32'h02);
        apb_write(16'hC, 32'h0, 4'hF);

        // Receive two frames without reading: second one overruns
        apb_write(16'h8, 32'(RX_DIV), 4'hF);
        apb_write(16'hC, 32'h6, 4'hF);
        applyStimulus(8'h3C, 1'b1, 1'b0);
        applyStimulus(8'h55, 1'b1, 1'b0);
        wait_cycles(3);
        checkOutput("rx_irq_on", 32'(irq), 32'h1);
        check_reg("rx_ovr_status", 16'h4, 32'h0E);
        check_reg("rx_data_3c", 16'h0, 32'h3C);
        check_reg("rx_after_read", 16'h4, 32'h0A);
        apb_write(16'h4, 32'h08, 4'hF);
        check_reg("rx_ovr_clear", 16'h4, 32'h02);
        checkOutput("rx_irq_off", 32'(irq), 32'h0);

        // Bad stop bit: byte still stored, FRAME_ERR set
        applyStimulus(8'h81, 1'b0, 1'b0);
        wait_cycles(3);
        check_reg("frame_err_status", 16'h4, 32'h26);
        check_reg("frame_err_data", 16'h0, 32'h81);
        apb_write(16'h4, 32'h20, 4'hF);
        check_reg("frame_err_clear", 16'h4, 32'h02);

        // One-cycle glitch is rejected as a false start
        uart_rx = 1'b0;
        @(posedge pclk); #1;
        uart_rx = 1'b1;
        wait_cycles(100);
        check_reg("glitch_status", 16'h4, 32'h02);
        checkOutput("glitch_irq", 32'(irq), 32'h0);

`ifdef UART_PARITY_EN
        applyStimulus(8'h07, 1'b1, 1'b1);
        wait_cycles(3);
        check_reg("par_err_status", 16'h4, 32'h46);
        check_reg("par_err_data", 16'h0, 32'h07);
        apb_write(16'h4, 32'h40, 4'hF);
        check_reg("par_err_clear", 16'h4, 32'h02);
        apb_write(16'h8, 32'd4, 4'hF);
        apb_write(16'hC, 32'h1, 4'hF);
        check_tx_frame(8'h07, "tx_07");
`endif

        // Asynchronous reset in the middle of a frame
        apb_write(16'h8, 32'd4, 4'hF);
        apb_write(16'hC, 32'h1, 4'hF);
        apb_write(16'h0, 32'h00, 4'hF);
        wait_cycles(8);
        checkOutput("mid_frame_low", 32'(uart_tx), 32'h0);
        presetn = 1'b0;
        #2;
        checkOutput("async_rst_tx", 32'(uart_tx), 32'h1);
        #5 presetn = 1'b1;
        @(posedge pclk); #1;
        check_reg("post_rst_status", 16'h4, 32'h02);
        check_reg("post_rst_baud", 16'h8, 32'd434);
        check_reg("post_rst_ctrl", 16'hC, 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
